// File: rtl/fp32_to_int32_scaled_pipe.sv
// FP32 to signed int32 fixed-point converter (round-to-nearest-even, saturating).
// Three-stage pipeline: unpack/classify, shift/round, sign/saturate; all stages stall together.
module fp32_to_int32_scaled_pipe #(
  parameter int FRAC_IN = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        ovf,
  output logic        inv,
  output logic        inexact
);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  logic              adv_s;
  logic [7:0]        exp_s;
  logic [22:0]       man_s;
  logic signed [9:0] ef_s;
  cls_t              cls_s;
  logic              inx_in_s;

  logic              v1_r;
  logic              sign1_r;
  cls_t              cls1_r;
  logic signed [9:0] ef1_r;
  logic [23:0]       sig1_r;
  logic              inx1_r;

  logic signed [9:0] sh_s;
  logic [9:0]        rsh_s;
  logic [49:0]       ext_s;
  logic              guard_s;
  logic              sticky_s;
  logic [32:0]       mag_s;
  logic              big_s;
  logic              inx2_s;

  logic              v2_r;
  logic              sign2_r;
  cls_t              cls2_r;
  logic [32:0]       mag2_r;
  logic              big2_r;
  logic              inx2_r;

  logic [31:0]       res_s;
  logic              ovf_s;
  logic              inv_s;
  logic              inx3_s;

  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  // Stage 1: unbiased exponent plus output scaling (ef = E + FRAC_IN), and operand class.
  always_comb begin
    exp_s    = fp_in[30:23];
    man_s    = fp_in[22:0];
    ef_s     = $signed({2'b00, exp_s}) - 10'sd127 + $signed(10'(FRAC_IN));
    inx_in_s = 1'b0;
    if (exp_s == 8'd0) begin
      cls_s    = CLS_ZERO;
      inx_in_s = (man_s != 23'd0);
    end else if (exp_s == 8'hFF) begin
      cls_s = (man_s != 23'd0) ? CLS_NAN : CLS_INF;
    end else begin
      cls_s = CLS_NORM;
    end
  end

  // Stage 2: align significand; right shifts keep guard/sticky for RNE rounding.
  always_comb begin
    sh_s     = ef1_r - 10'sd23;
    rsh_s    = 10'd0;
    ext_s    = 50'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    mag_s    = 33'd0;
    big_s    = 1'b0;
    inx2_s   = inx1_r;
    if (cls1_r == CLS_NORM) begin
      big_s = (ef1_r >= 10'sd31);
      if (ef1_r >= 10'sd32) begin
        // Beyond 2^32 the exact magnitude is irrelevant; clamp so both signs saturate.
        mag_s = 33'h1_FFFF_FFFF;
      end else if (!sh_s[9]) begin
        mag_s = {9'd0, sig1_r} << sh_s[3:0];
      end else begin
        rsh_s = 10'(-sh_s);
        if (rsh_s > 10'd25) begin
          mag_s  = 33'd0;
          inx2_s = 1'b1;
        end else begin
          ext_s    = {sig1_r, 26'd0} >> rsh_s[4:0];
          guard_s  = ext_s[25];
          sticky_s = |ext_s[24:0];
          mag_s    = {9'd0, ext_s[49:26]} + {32'd0, guard_s & (sticky_s | ext_s[26])};
          inx2_s   = guard_s | sticky_s;
        end
      end
    end else begin
      mag_s = 33'd0;
    end
  end

  // Stage 3: apply sign and saturate; -2^31 is representable without overflow.
  always_comb begin
    res_s  = 32'd0;
    ovf_s  = 1'b0;
    inv_s  = 1'b0;
    inx3_s = 1'b0;
    case (cls2_r)
      CLS_ZERO: begin
        inx3_s = inx2_r;
      end
      CLS_NAN: begin
        inv_s = 1'b1;
      end
      CLS_INF: begin
        res_s = sign2_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ovf_s = 1'b1;
      end
      CLS_NORM: begin
        if (!sign2_r) begin
          if (big2_r || (mag2_r > 33'h0_7FFF_FFFF)) begin
            res_s = 32'h7FFF_FFFF;
            ovf_s = 1'b1;
          end else begin
            res_s  = mag2_r[31:0];
            inx3_s = inx2_r;
          end
        end else begin
          if (mag2_r > 33'h0_8000_0000) begin
            res_s = 32'h8000_0000;
            ovf_s = 1'b1;
          end else if (mag2_r == 33'h0_8000_0000) begin
            res_s  = 32'h8000_0000;
            inx3_s = inx2_r;
          end else begin
            res_s  = 32'd0 - mag2_r[31:0];
            inx3_s = inx2_r;
          end
        end
      end
      default: begin
        res_s = 32'd0;
      end
    endcase
  end

  // Pipeline registers: every stage advances together on adv, otherwise all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      sign1_r   <= 1'b0;
      cls1_r    <= CLS_ZERO;
      ef1_r     <= 10'sd0;
      sig1_r    <= 24'd0;
      inx1_r    <= 1'b0;
      v2_r      <= 1'b0;
      sign2_r   <= 1'b0;
      cls2_r    <= CLS_ZERO;
      mag2_r    <= 33'd0;
      big2_r    <= 1'b0;
      inx2_r    <= 1'b0;
      out_valid <= 1'b0;
      int_out   <= 32'd0;
      ovf       <= 1'b0;
      inv       <= 1'b0;
      inexact   <= 1'b0;
    end else if (adv_s) begin
      v1_r      <= in_valid;
      sign1_r   <= fp_in[31];
      cls1_r    <= cls_s;
      ef1_r     <= ef_s;
      sig1_r    <= {1'b1, man_s};
      inx1_r    <= inx_in_s;
      v2_r      <= v1_r;
      sign2_r   <= sign1_r;
      cls2_r    <= cls1_r;
      mag2_r    <= mag_s;
      big2_r    <= big_s;
      inx2_r    <= inx2_s;
      out_valid <= v2_r;
      int_out   <= res_s;
      ovf       <= ovf_s;
      inv       <= inv_s;
      inexact   <= inx3_s;
    end else begin
      v1_r      <= v1_r;
      v2_r      <= v2_r;
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_scaled_pipe.sv
// Directed bench for fp32_to_int32_scaled_pipe (FRAC_IN=7): vectors, stalls, reset.
module tb_fp32_to_int32_scaled_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        ovf;
  logic        inv;
  logic        inexact;

  int tests;
  int fails;

  fp32_to_int32_scaled_pipe #(.FRAC_IN(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .ovf       (ovf),
    .inv       (inv),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one value with out_ready=1 and check latency, result and flags.
  task automatic run_vec(input string tag, input logic [31:0] fp, input logic [31:0] e_int,
                         input logic e_ovf, input logic e_inv, input logic e_inx);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    fp_in     = fp;
    out_ready = 1'b1;
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_int"}, int_out, e_int);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    chk({tag, "_inv"}, {31'd0, inv}, {31'd0, e_inv});
    chk({tag, "_inexact"}, {31'd0, inexact}, {31'd0, e_inx});
  endtask

  logic [31:0] bp_vals [8];
  int          sent;
  int          got;

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    fp_in     = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_int_out", int_out, 32'd0);
    chk("rst_flags", {29'd0, ovf, inv, inexact}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_vec("one",      32'h3F80_0000, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    run_vec("m2p5",     32'hC020_0000, 32'hFFFF_FEC0, 1'b0, 1'b0, 1'b0);
    run_vec("tie_even0",32'h3B80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    run_vec("tie_up2",  32'h3C40_0000, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    run_vec("ulp075",   32'h3BC0_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    run_vec("sat_pos",  32'h4B80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_vec("min_neg",  32'hCB80_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_vec("sat_neg",  32'hCC00_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_vec("pinf",     32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_vec("ninf",     32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_vec("nan",      32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_vec("negzero",  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_vec("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    // 2^-30 lies far below the LSB: sticky only, rounds to zero.
    run_vec("tiny",     32'h3080_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // Back-pressure stream of 1.0 .. 8.0, expected k*128 in order.
    bp_vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      fp_in     = (sent < 8) ? bp_vals[sent] : 32'd0;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        chk("bp_data", int_out, 32'(got + 1) << 7);
        if (out_ready) got++;
      end
    end
    in_valid = 1'b0;
    chk("bp_all_received", 32'(got), 32'd8);

    // Drain, then fill with 3 results while out_ready=0 and reset mid-stall.
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fp_in     = 32'h7F80_0000;
    @(posedge clk); #1;
    fp_in = 32'h3F80_0000;
    @(posedge clk); #1;
    fp_in = 32'h7FC0_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_full_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_full_ovf", {31'd0, ovf}, 32'd1);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_int", int_out, 32'd0);
    chk("mid_rst_flags", {29'd0, ovf, inv, inexact}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
